mtl_pixel_feeder: RTL and testbench

Frame-buffer reader that supplies pixels to the MTL LCD timing generator. It fetches one full 800x480 frame per display frame from the SDRAM/MMU read port in fixed-length bursts into a show-ahead FIFO. It pops one 32-bit RGB word per cycle in which the display requests a pixel. It is the responder for the display's `next_display_active` / `iREAD_DATA` interface.

---
 rtl/mtl_pkg.sv | 18 +
 rtl/mtl_pixel_feeder_if.sv | 15 +
 rtl/mtl_pixel_fifo.sv | 60 ++++++
 rtl/mtl_pixel_feeder.sv | 162 ++++++++++++++++
 tb/tb_mtl_pixel_feeder.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mtl_pkg.sv
// Shared MTL display types: frame geometry, pixel word, feeder FSM states, underflow colours.
package mtl_pkg;
    localparam int H_ACTIVE = 800;
    localparam int V_ACTIVE = 480;

    typedef logic [31:0] pixel_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT_DATA,
        ST_DONE,
        ST_FLUSH
    } feeder_state_t;

    localparam pixel_t UF_COLOR_DBG = 32'h00FF00FF;
    localparam pixel_t UF_COLOR_STD = 32'h00000000;
endpackage

// File: rtl/mtl_pixel_feeder_if.sv
// Burst read port between the pixel feeder (master) and the SDRAM/MMU (slave).
interface mtl_pixel_feeder_if #(
    parameter int ADDR_W = 24
);
    logic              oMEM_REQ;
    logic [ADDR_W-1:0] oMEM_ADDR;
    logic              iMEM_ACK;
    logic              iMEM_VALID;
    logic [31:0]       iMEM_DATA;

    modport master (output oMEM_REQ, output oMEM_ADDR,
                    input  iMEM_ACK, input iMEM_VALID, input iMEM_DATA);
    modport slave  (input  oMEM_REQ, input oMEM_ADDR,
                    output iMEM_ACK, output iMEM_VALID, output iMEM_DATA);
endinterface

// File: rtl/mtl_pixel_fifo.sv
// Show-ahead FIFO: head is combinational from storage; flush beats a same-cycle push or pop.
module mtl_pixel_fifo
    import mtl_pkg::*;
#(
    parameter int DEPTH = 64,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    flush_i,
    input  logic    push_i,
    input  logic    pop_i,
    input  pixel_t  din_i,
    output pixel_t  head_o,
    output logic    empty_o,
    output logic [AW:0] count_o
);
    pixel_t        mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    always_comb begin
        do_push = push_i && !flush_i;
        do_pop  = pop_i && !flush_i && (cnt_q != '0);
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        if (flush_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + AW'(1);
            if (do_pop)  rd_d = rd_q + AW'(1);
            cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: cnt_q gates every read of it.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

    assign head_o  = mem_q[rd_q];
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
endmodule

// File: rtl/mtl_pixel_feeder.sv
// Frame-buffer reader: bursts one frame per iNew_Frame into a show-ahead FIFO popped by the LCD.
// MTL_FEEDER_UNDERFLOW_DBG_EN selects magenta underflow colour and a saturating underflow counter.
module mtl_pixel_feeder #(
    parameter int FRAME_BASE = 0,
    parameter int H_ACTIVE   = mtl_pkg::H_ACTIVE,
    parameter int V_ACTIVE   = mtl_pkg::V_ACTIVE,
    parameter int BURST_LEN  = 16,
    parameter int FIFO_DEPTH = 64,
    parameter int ADDR_W     = 24
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iNew_Frame,
    input  logic        iRead_en,
    output logic [31:0] oREAD_DATA,
    output logic        oUNDERFLOW,
    output logic [15:0] oUNDERFLOW_CNT,
    mtl_pixel_feeder_if.master mem_if
);
    import mtl_pkg::*;

    localparam int FRAME_WORDS = H_ACTIVE * V_ACTIVE;
    localparam int WL_W        = $clog2(FRAME_WORDS + 1);
    localparam int BO_W        = $clog2(BURST_LEN + 1);
    localparam int FC_W        = $clog2(FIFO_DEPTH) + 1;
    localparam int RS_W        = FC_W + 1;

`ifdef MTL_FEEDER_UNDERFLOW_DBG_EN
    localparam pixel_t UF_COLOR = UF_COLOR_DBG;
`else
    localparam pixel_t UF_COLOR = UF_COLOR_STD;
`endif

    feeder_state_t     state_q, state_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WL_W-1:0]   words_q, words_d;
    logic [BO_W-1:0]   beats_q, beats_d;
    logic              uf_q, uf_d;

    logic              fifo_push, fifo_pop, fifo_empty;
    logic [FC_W-1:0]   fifo_count;
    pixel_t            fifo_head;
    logic [RS_W-1:0]   reserved;
    logic              req_ok, uf_ev;

    assign fifo_pop = iRead_en && !fifo_empty;
    assign uf_ev    = iRead_en && fifo_empty;
    assign reserved = RS_W'(fifo_count) + RS_W'(beats_q);
    assign req_ok   = (words_q != '0) && (reserved <= RS_W'(FIFO_DEPTH - BURST_LEN));

    mtl_pixel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (iCLK),
        .rst     (iRST),
        .flush_i (iNew_Frame),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .din_i   (mem_if.iMEM_DATA),
        .head_o  (fifo_head),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        addr_d    = addr_q;
        words_d   = words_q;
        beats_d   = beats_q;
        uf_d      = uf_q || uf_ev;
        fifo_push = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (req_q) begin
                    if (mem_if.iMEM_ACK) begin
                        req_d   = 1'b0;
                        addr_d  = addr_q + ADDR_W'(BURST_LEN);
                        words_d = words_q - WL_W'(BURST_LEN);
                        beats_d = BO_W'(BURST_LEN);
                        state_d = ST_WAIT_DATA;
                    end
                end else if (req_ok) begin
                    req_d = 1'b1;
                end
            end
            ST_WAIT_DATA: begin
                if (mem_if.iMEM_VALID) begin
                    fifo_push = 1'b1;
                    beats_d   = beats_q - BO_W'(1);
                    if (beats_q == BO_W'(1)) state_d = (words_q == '0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FLUSH: begin
                if (beats_q == '0) begin
                    state_d = ST_FETCH;
                end else if (mem_if.iMEM_VALID) begin
                    beats_d = beats_q - BO_W'(1);
                    if (beats_q == BO_W'(1)) state_d = ST_FETCH;
                end
            end
            default: ;
        endcase

        if (iNew_Frame) begin
            words_d   = WL_W'(FRAME_WORDS);
            addr_d    = ADDR_W'(FRAME_BASE);
            uf_d      = 1'b0;
            fifo_push = 1'b0;
            // Any burst still owed by memory must drain before the new frame may request.
            if (state_q == ST_WAIT_DATA || state_q == ST_FLUSH ||
                (state_q == ST_FETCH && req_q && mem_if.iMEM_ACK)) begin
                state_d = ST_FLUSH;
                req_d   = 1'b0;
            end else begin
                state_d = ST_FETCH;
                beats_d = '0;
                req_d   = !(state_q == ST_FETCH && req_q);
            end
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            addr_q  <= ADDR_W'(FRAME_BASE);
            words_q <= '0;
            beats_q <= '0;
            uf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            words_q <= words_d;
            beats_q <= beats_d;
            uf_q    <= uf_d;
        end
    end

`ifdef MTL_FEEDER_UNDERFLOW_DBG_EN
    logic [15:0] uf_cnt_q, uf_cnt_d;

    always_comb begin
        uf_cnt_d = uf_cnt_q;
        if (uf_ev && uf_cnt_q != 16'hFFFF) uf_cnt_d = uf_cnt_q + 16'd1;
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) uf_cnt_q <= '0;
        else      uf_cnt_q <= uf_cnt_d;
    end

    assign oUNDERFLOW_CNT = uf_cnt_q;
`else
    assign oUNDERFLOW_CNT = '0;
`endif

    assign mem_if.oMEM_REQ  = req_q;
    assign mem_if.oMEM_ADDR = addr_q;
    assign oUNDERFLOW       = uf_q;
    assign oREAD_DATA       = fifo_empty ? UF_COLOR : fifo_head;
endmodule

// File: tb/tb_mtl_pixel_feeder.sv
// Directed bench for mtl_pixel_feeder on a reduced 32x4 frame with a 5-cycle-ack / 3-cycle-beat memory.
module tb_mtl_pixel_feeder;
    import mtl_pkg::*;

    localparam int BURST = 16;
    localparam int DEPTH = 64;
    localparam int HA    = 32;
    localparam int VA    = 4;
    localparam int NBUR  = HA * VA / BURST;
`ifdef MTL_FEEDER_UNDERFLOW_DBG_EN
    localparam logic [31:0] UFC = 32'h00FF00FF;
`else
    localparam logic [31:0] UFC = 32'h00000000;
`endif

    typedef struct {
        logic        rd;
        logic [31:0] data;
        logic        uf;
        logic [15:0] cnt;
    } uf_vec_t;

    logic        clk, rst, iNew_Frame, iRead_en;
    logic [31:0] oREAD_DATA;
    logic        oUNDERFLOW;
    logic [15:0] oUNDERFLOW_CNT;

    mtl_pixel_feeder_if #(.ADDR_W(24)) mif ();

    mtl_pixel_feeder #(
        .FRAME_BASE(0), .H_ACTIVE(HA), .V_ACTIVE(VA),
        .BURST_LEN(BURST), .FIFO_DEPTH(DEPTH), .ADDR_W(24)
    ) dut (
        .iCLK(clk), .iRST(rst), .iNew_Frame(iNew_Frame), .iRead_en(iRead_en),
        .oREAD_DATA(oREAD_DATA), .oUNDERFLOW(oUNDERFLOW), .oUNDERFLOW_CNT(oUNDERFLOW_CNT),
        .mem_if(mif)
    );

    int checks = 0;
    int fails  = 0;
    int gen    = 0;
    int gen_beats = 0;
    int occ = 0;
    bit occ_on = 0;
    int full_push_err = 0;
    logic req_prev = 0;
    logic [23:0] req_addr_q[$];
    logic [23:0] ack_addr_q[$];
    int          pend_q[$];

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Memory model: ack on the 5th cycle of a held request, beats start 3 cycles later.
    initial begin
        int req_cnt, bt_left, bt_wait;
        logic [23:0] bt_addr;
        logic [7:0]  bt_gen;
        req_cnt = 0; bt_left = 0; bt_wait = 0; bt_addr = '0; bt_gen = '0;
        mif.iMEM_ACK = 0; mif.iMEM_VALID = 0; mif.iMEM_DATA = '0;
        forever begin
            @(negedge clk);
            mif.iMEM_ACK = 0;
            mif.iMEM_VALID = 0;
            if (bt_left > 0) begin
                if (bt_wait > 0) bt_wait--;
                else begin
                    mif.iMEM_VALID = 1;
                    mif.iMEM_DATA  = {8'h00, bt_gen, bt_addr[15:0]};
                    bt_addr++;
                    bt_left--;
                end
            end
            if (mif.oMEM_REQ) begin
                req_cnt++;
                if (req_cnt == 1) begin
                    req_addr_q.push_back(mif.oMEM_ADDR);
                    pend_q.push_back(bt_left);
                end
                if (req_cnt == 5) begin
                    mif.iMEM_ACK = 1;
                    req_cnt = 0;
                    ack_addr_q.push_back(mif.oMEM_ADDR);
                    bt_addr = mif.oMEM_ADDR;
                    bt_gen  = gen[7:0];
                    bt_left = BURST;
                    bt_wait = 3;
                end
            end else begin
                req_cnt = 0;
            end
        end
    end

    // Post-edge monitor: beats of the current frame, and FIFO occupancy at each request rise.
    initial begin
        bit pop;
        forever begin
            @(posedge clk);
            #1;
            if (mif.iMEM_VALID && mif.iMEM_DATA[23:16] == gen[7:0]) gen_beats++;
            if (occ_on) begin
                pop = iRead_en && (occ > 0);
                occ = occ + int'(mif.iMEM_VALID) - int'(pop);
                if (mif.oMEM_REQ && !req_prev) chk("req_reserve_le_48", 32'(occ <= DEPTH - BURST), 32'd1);
            end
            req_prev = mif.oMEM_REQ;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (dut.u_fifo.do_push && dut.u_fifo.cnt_q == DEPTH) full_push_err++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    task automatic new_frame();
        @(negedge clk);
        iNew_Frame = 1;
        gen++;
        gen_beats = 0;
        req_addr_q.delete();
        ack_addr_q.delete();
        pend_q.delete();
        @(negedge clk);
        iNew_Frame = 0;
        #1;
    endtask

    task automatic wait_beats(input int n, input string nm);
        int k;
        k = 0;
        while (gen_beats < n && k < 500) begin
            @(posedge clk);
            #2;
            k++;
        end
        chk(nm, 32'(gen_beats >= n), 32'd1);
    endtask

    task automatic pop_seq(input int first, input int n, input string nm);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            iRead_en = 1;
            #1;
            chk(nm, oREAD_DATA, {8'h00, gen[7:0], 16'(first + k)});
        end
        @(negedge clk);
        iRead_en = 0;
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_req"},  32'(mif.oMEM_REQ), 32'd0);
        chk({nm, "_addr"}, 32'(mif.oMEM_ADDR), 32'd0);
        chk({nm, "_uf"},   32'(oUNDERFLOW), 32'd0);
        chk({nm, "_cnt"},  32'(oUNDERFLOW_CNT), 32'd0);
        chk({nm, "_data"}, oREAD_DATA, UFC);
    endtask

    initial begin
        uf_vec_t     vt [12];
        logic [23:0] exp_addr [NBUR];
        int          pix;
        bit          rd;

        for (int j = 0; j < 12; j++) begin
            vt[j].rd   = (j >= 1 && j <= 10);
            vt[j].data = UFC;
            vt[j].uf   = (j >= 1);
`ifdef MTL_FEEDER_UNDERFLOW_DBG_EN
            vt[j].cnt  = 16'((j > 10) ? 10 : j);
`else
            vt[j].cnt  = 16'd0;
`endif
        end
        for (int i = 0; i < NBUR; i++) exp_addr[i] = 24'(i * BURST);

        rst = 1; iNew_Frame = 0; iRead_en = 0;
        repeat (3) @(negedge clk);
        #1;
        chk_reset_outputs("reset");
        chk("reset_state", 32'(dut.state_q), 32'(ST_IDLE));
        @(negedge clk);
        rst = 0;

        // Reads with no frame started: underflow colour, sticky flag, optional counter.
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            iRead_en = vt[j].rd;
            #1;
            chk("uf_vec_data", oREAD_DATA, vt[j].data);
            @(posedge clk);
            #1;
            chk("uf_vec_flag", 32'(oUNDERFLOW), 32'(vt[j].uf));
            chk("uf_vec_cnt",  32'(oUNDERFLOW_CNT), 32'(vt[j].cnt));
            chk("uf_vec_noreq", 32'(mif.oMEM_REQ), 32'd0);
        end
        @(negedge clk);
        iRead_en = 0;

        // Full frame with line timing: 32 active of 64 cycles after a 100-cycle blank.
        new_frame();
        chk("frame_first_req",  32'(mif.oMEM_REQ), 32'd1);
        chk("frame_first_addr", 32'(mif.oMEM_ADDR), 32'd0);
        chk("frame_uf_cleared", 32'(oUNDERFLOW), 32'd0);
        occ = 0;
        occ_on = 1;
        pix = 0;
        for (int c = 0; c < 100 + VA * 64; c++) begin
            @(negedge clk);
            rd = (c >= 100) && (((c - 100) % 64) < HA);
            iRead_en = rd;
            #1;
            if (rd) begin
                chk("frame_pixel", oREAD_DATA, {8'h00, gen[7:0], 16'(pix)});
                pix++;
            end
        end
        @(negedge clk);
        iRead_en = 0;
        occ_on = 0;
        chk("frame_no_underflow", 32'(oUNDERFLOW), 32'd0);
        chk("frame_state_done", 32'(dut.state_q), 32'(ST_DONE));
        chk("frame_ack_count", 32'(ack_addr_q.size()), 32'(NBUR));
        for (int i = 0; i < NBUR; i++)
            if (i < ack_addr_q.size()) chk("frame_ack_addr", 32'(ack_addr_q[i]), 32'(exp_addr[i]));

        // New frame with 7 of 16 beats of the second burst delivered.
        new_frame();
        wait_beats(BURST + 7, "flush_wait_beats");
        new_frame();
        chk("flush_state", 32'(dut.state_q), 32'(ST_FLUSH));
        repeat (60) @(negedge clk);
        chk("flush_req_seen", 32'(req_addr_q.size() > 0), 32'd1);
        if (req_addr_q.size() > 0) begin
            chk("flush_next_addr", 32'(req_addr_q[0]), 32'd0);
            chk("flush_drained_first", 32'(pend_q[0]), 32'd0);
        end
        pop_seq(0, BURST, "flush_pop");

        // Push and pop in the same cycle with one word held.
        new_frame();
        wait_beats(1, "pp_wait_beat");
        @(negedge clk);
        iRead_en = 1;
        #1;
        chk("pp_valid_same_cycle", 32'(mif.iMEM_VALID), 32'd1);
        chk("pp_head0", oREAD_DATA, {8'h00, gen[7:0], 16'd0});
        @(negedge clk);
        iRead_en = 0;
        #1;
        chk("pp_count", 32'(dut.u_fifo.count_o), 32'd1);
        chk("pp_head1", oREAD_DATA, {8'h00, gen[7:0], 16'd1});
        repeat (40) @(negedge clk);
        pop_seq(1, BURST - 1, "pp_order");

        // Reset in the middle of a burst, stray beats land while held in reset.
        new_frame();
        wait_beats(5, "rst_wait_beats");
        @(negedge clk);
        rst = 1;
        #1;
        chk_reset_outputs("midrst");
        repeat (30) @(negedge clk);
        #1;
        chk_reset_outputs("midrst_hold");
        @(negedge clk);
        rst = 0;
        repeat (5) @(negedge clk);
        #1;
        chk("rst_idle_noreq", 32'(mif.oMEM_REQ), 32'd0);
        chk("rst_fifo_empty", oREAD_DATA, UFC);
        new_frame();
        chk("rst_first_req",  32'(mif.oMEM_REQ), 32'd1);
        chk("rst_first_addr", 32'(mif.oMEM_ADDR), 32'd0);
        repeat (60) @(negedge clk);
        pop_seq(0, BURST, "rst_pop");

        chk("no_push_into_full", 32'(full_push_err), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
